// File: rtl/frame_scheduler.sv
// Per-frame sequencer: swaps the framebuffer, streams the triangle table to the
// rasterizer over valid/ready, waits for the rasterizer to drain, then signals done.
package frame_scheduler_pkg;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [23:0] color;
  } vertex_t;

  typedef struct packed {
    vertex_t v0;
    vertex_t v1;
    vertex_t v2;
  } triangle_t;
endpackage

module frame_scheduler
  import frame_scheduler_pkg::*;
#(
  parameter int  MAX_TRIS = 64,
  parameter int  TRI_W    = $bits(triangle_t),
  localparam int AW       = $clog2(MAX_TRIS),
  localparam int CW       = $clog2(MAX_TRIS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             tbl_we,
  input  logic [AW-1:0]    tbl_waddr,
  input  logic [TRI_W-1:0] tbl_wdata,
  input  logic             cnt_we,
  input  logic [CW-1:0]    cnt_wdata,
  output logic             tbl_busy,
  output logic             swap,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TRI_W-1:0] out_tri,
  input  logic             raster_busy,
  output logic             frame_done,
  output logic             frame_dropped,
  output logic [7:0]       drop_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SWAP  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_OFFER = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [TRI_W-1:0] mem [MAX_TRIS];

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    active_cnt_q, active_cnt_d;
  logic [CW-1:0]    count_q, count_d;
  logic             low_q, low_d;
  logic [TRI_W-1:0] out_tri_q, out_tri_d;
  logic             dropped_q, dropped_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  // Table is host-owned while idle; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (tbl_we && state_q == S_IDLE) mem[tbl_waddr] <= tbl_wdata;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    active_cnt_d = active_cnt_q;
    count_d      = count_q;
    low_d        = low_q;
    out_tri_d    = out_tri_q;
    dropped_d    = 1'b0;
    drop_cnt_d   = drop_cnt_q;

    if (frame_start && state_q != S_IDLE) begin
      dropped_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (cnt_we) count_d = (cnt_wdata > CW'(MAX_TRIS)) ? CW'(MAX_TRIS) : cnt_wdata;
        if (frame_start) state_d = S_SWAP;
      end
      S_SWAP: begin
        active_cnt_d = count_q;
        idx_d        = '0;
        low_d        = 1'b0;
        state_d      = (count_q != '0) ? S_FETCH : S_DRAIN;
      end
      S_FETCH: begin
        // Synchronous read: data is captured here and held through OFFER.
        out_tri_d = mem[idx_q];
        state_d   = S_OFFER;
      end
      S_OFFER: begin
        if (out_ready) begin
          if (CW'(idx_q) == active_cnt_q - CW'(1)) begin
            low_d   = 1'b0;
            state_d = S_DRAIN;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        // Two low samples in a row cover busy rising one cycle after the last accept.
        if (raster_busy) low_d = 1'b0;
        else if (low_q)  state_d = S_DONE;
        else             low_d = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      active_cnt_q <= '0;
      count_q      <= '0;
      low_q        <= 1'b0;
      out_tri_q    <= '0;
      dropped_q    <= 1'b0;
      drop_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      active_cnt_q <= active_cnt_d;
      count_q      <= count_d;
      low_q        <= low_d;
      out_tri_q    <= out_tri_d;
      dropped_q    <= dropped_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign tbl_busy      = (state_q != S_IDLE);
  assign swap          = (state_q == S_SWAP);
  assign out_valid     = (state_q == S_OFFER);
  assign frame_done    = (state_q == S_DONE);
  assign out_tri       = out_tri_q;
  assign frame_dropped = dropped_q;
  assign drop_count    = drop_cnt_q;

endmodule

// File: doc/frame_scheduler.md
# frame_scheduler

Per-frame sequencer between the frame-start strobe, a host-loaded triangle table, the rasterizer and the double framebuffer. On each accepted frame start it:

- pulses the framebuffer swap;
- streams the active triangle list into the rasterizer over a valid/ready handshake;
- waits for the rasterizer to drain, then reports frame completion.

Frame starts that arrive while a frame is still in progress are dropped and counted. The block runs entirely in the renderer clock domain.

## Interface
- `MAX_TRIS`, 64, triangle table depth; AW = $clog2(MAX_TRIS), CW = $clog2(MAX_TRIS+1)
- `TRI_W`, $bits(triangle_t), width of one packed triangle (three vertices: pos + color)
- `clk` in 1 — renderer clock; one clock; all logic on posedge
- `rst_n` in 1 — reset is asynchronous and active-low
- `frame_start` in 1 — single-cycle frame-start pulse, already synchronised into `clk`
- `tbl_we` in 1 — triangle table write strobe
- `tbl_waddr` in AW — table write index
- `tbl_wdata` in TRI_W — triangle to store
- `cnt_we` in 1 — write triangle count register
- `cnt_wdata` in CW — new count; values > MAX_TRIS clamp to MAX_TRIS
- `tbl_busy` out 1 — high whenever state != IDLE; table/count writes ignored while high
- `swap` out 1 — one-cycle framebuffer swap pulse
- `out_valid` out 1 — triangle offered to rasterizer
- `out_ready` in 1 — rasterizer accepts
- `out_tri` out TRI_W — offered triangle, stable while out_valid && !out_ready
- `raster_busy` in 1 — rasterizer busy
- `frame_done` out 1 — one-cycle pulse when frame fully rasterized
- `frame_dropped` out 1 — one-cycle pulse when a frame_start is rejected
- `drop_count` out 8 — saturating count of dropped frame starts

## Operation
- Table: MAX_TRIS x TRI_W single-port-write, synchronous-read memory, 1-cycle read latency. Contents are not reset.
- `count_reg` is reset to 0. It is written only in IDLE (clamped) and copied to `active_cnt` in SWAP.
- States:
  - IDLE: frame_start -> SWAP.
  - SWAP: swap=1 for this cycle; active_cnt <= count_reg; idx <= 0; -> FETCH if count_reg != 0, else DRAIN.
  - FETCH: drive read address idx; -> OFFER.
  - OFFER: out_valid=1, out_tri = read data (registered). On out_valid && out_ready: if idx == active_cnt-1 -> DRAIN, else idx+1 -> FETCH.
  - DRAIN: exit when raster_busy has been sampled low on 2 consecutive cycles; -> DONE.
  - DONE: frame_done=1 for one cycle; -> IDLE.
- frame_start in any state other than IDLE: frame_dropped=1 next cycle; drop_count += 1, saturating at 255; the state machine is unaffected.
- frame_start arriving in the same cycle as the DONE->IDLE transition is a drop; only frame_start sampled while in IDLE is accepted.
- tbl_we / cnt_we in IDLE take effect at the clock edge. If cnt_we and frame_start occur in the same IDLE cycle, the new count is used by that frame.
- out_valid never drops without a handshake. out_tri holds its value from OFFER entry until the handshake.

## Timing
- Reset values: swap=0, out_valid=0, out_tri=0, frame_done=0, frame_dropped=0, drop_count=0, tbl_busy=0, state=IDLE, count_reg=0.
- Asserting rst_n low mid-frame immediately (asynchronously) clears all outputs and the state. No swap or frame_done is generated on reset release.
- frame_start at edge t (IDLE) -> swap high in cycle t+1 and tbl_busy high from t+1. The first out_valid is in cycle t+3 (SWAP t+1, FETCH t+2, OFFER t+3).
- Handshake at edge k -> next out_valid in cycle k+2. Maximum throughput is 1 triangle / 2 cycles with out_ready held high.
- Last handshake at k -> DRAIN from k+1. Minimum frame_done is at k+3 if raster_busy stays low. The 2-cycle low qualification covers the rasterizer's busy rise one cycle after acceptance.
- count=0: frame_start at t -> swap t+1, frame_done earliest t+4.
- frame_done falls to 0 in the cycle after its pulse; tbl_busy drops in the same cycle frame_done pulses ends (IDLE).

## Test plan
- Load 4 triangles with count=4, pulse frame_start, out_ready=1, raster_busy low -> swap at t+1; exactly 4 handshakes with out_tri = entries 0..3 in order at cycles t+3, t+5, t+7, t+9; frame_done at t+12.
- Same setup with out_ready toggling randomly and raster_busy high for 20 cycles after each accept -> out_tri stable while stalled, no out_valid gaps before handshake, frame_done only after raster_busy has been low for 2 cycles.
- count=0 -> swap pulse, zero out_valid, frame_done at t+4.
- frame_start every 3 cycles during a 4-triangle frame -> frame_dropped per rejected pulse, drop_count increments; after 300 drops it reads 255.
- tbl_we and cnt_we asserted while tbl_busy=1 -> table and count unchanged; the next frame replays the old data.
- rst_n pulsed low while in OFFER -> out_valid=0 immediately, state IDLE; the next frame_start behaves as in scenario 1 except count_reg=0 (reset) unless reloaded.
